// File: rtl/sec_add_pkg.sv
// Shared types and constants for the sequenced masked adder/subtractor.
package sec_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PHASE1 = 2'd1,
    ST_PHASE2 = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int RND_XY = 0;
  localparam int RND_XC = 1;
  localparam int RND_YC = 2;

  // Round counter must hold 0..K-2; never narrower than one bit.
  function automatic int rcnt_w(input int k);
    return (k - 1 > 1) ? $clog2(k - 1) : 1;
  endfunction

endpackage

// File: rtl/sec_and_dom.sv
// Single-bit two-stage domain-oriented masked AND: q0 ^ q1 = (a0 ^ a1) & (b0 ^ b1).
module sec_and_dom (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en1,
  input  logic en2,
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic r,
  output logic q0,
  output logic q1
);

  logic inner0_p1;
  logic inner1_p1;
  logic cross01_p1;
  logic cross10_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inner0_p1  <= 1'b0;
      inner1_p1  <= 1'b0;
      cross01_p1 <= 1'b0;
      cross10_p1 <= 1'b0;
      q0         <= 1'b0;
      q1         <= 1'b0;
    end else begin
      // stage 1: cross-domain products are masked before they are stored
      if (en1) begin
        inner0_p1  <= a0 & b0;
        inner1_p1  <= a1 & b1;
        cross01_p1 <= (a0 & b1) ^ r;
        cross10_p1 <= (a1 & b0) ^ r;
      end
      // stage 2: each domain only ever combines registered terms
      if (en2) begin
        q0 <= inner0_p1 ^ cross01_p1;
        q1 <= inner1_p1 ^ cross10_p1;
      end
    end
  end

endmodule

// File: rtl/sec_add_seq.sv
// Bit-serial first-order Boolean-masked adder/subtractor, one carry bit per
// PHASE1/PHASE2 round through three time-shared DOM AND gadgets.
module sec_add_seq
  import sec_add_pkg::*;
#(
  parameter int K = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         sub_i,
  input  logic [K-1:0] x0_i,
  input  logic [K-1:0] x1_i,
  input  logic [K-1:0] y0_i,
  input  logic [K-1:0] y1_i,
  input  logic [2:0]   rnd_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [K-1:0] z0_o,
  output logic [K-1:0] z1_o
);

  localparam int RW = rcnt_w(K);
  localparam logic [RW-1:0] R_LAST = RW'(K - 2);

  state_t        state;
  logic [RW-1:0] r_cnt;
  logic [K-1:0]  mask;
  logic [K-1:0]  xs0, xs1, ys0, ys1;
  logic [K-2:0]  zw0, zw1;
  logic [K-1:0]  zh0, zh1;
  logic          ci0, ci1;
  logic          first;

  logic xa0, xa1, ya0, ya1;
  logic cin0, cin1;
  logic xy_q0, xy_q1, xc_q0, xc_q1, yc_q0, yc_q1;
  logic en1, en2;
  logic zb0, zb1, msb0, msb1;

  assign en1 = (state == ST_PHASE1);
  assign en2 = (state == ST_PHASE2);

  // Only the selected bit of each share is forwarded to the gadgets.
  assign xa0 = |(xs0 & mask);
  assign xa1 = |(xs1 & mask);
  assign ya0 = |(ys0 & mask);
  assign ya1 = |(ys1 & mask);

  // Round 0 uses the latched initial carry; later rounds use the gadget outputs.
  assign cin0 = first ? ci0 : (xy_q0 ^ xc_q0 ^ yc_q0);
  assign cin1 = first ? ci1 : (xy_q1 ^ xc_q1 ^ yc_q1);

  assign zb0  = xa0 ^ ya0 ^ cin0;
  assign zb1  = xa1 ^ ya1 ^ cin1;
  assign msb0 = xs0[K-1] ^ ys0[K-1] ^ cin0;
  assign msb1 = xs1[K-1] ^ ys1[K-1] ^ cin1;

  sec_and_dom u_and_xy (
    .clk_i (clk_i), .rst_i (rst_i), .en1 (en1), .en2 (en2),
    .a0 (xa0), .a1 (xa1), .b0 (ya0), .b1 (ya1),
    .r (rnd_i[RND_XY]), .q0 (xy_q0), .q1 (xy_q1)
  );

  sec_and_dom u_and_xc (
    .clk_i (clk_i), .rst_i (rst_i), .en1 (en1), .en2 (en2),
    .a0 (xa0), .a1 (xa1), .b0 (cin0), .b1 (cin1),
    .r (rnd_i[RND_XC]), .q0 (xc_q0), .q1 (xc_q1)
  );

  sec_and_dom u_and_yc (
    .clk_i (clk_i), .rst_i (rst_i), .en1 (en1), .en2 (en2),
    .a0 (ya0), .a1 (ya1), .b0 (cin0), .b1 (cin1),
    .r (rnd_i[RND_YC]), .q0 (yc_q0), .q1 (yc_q1)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      r_cnt  <= '0;
      mask   <= '0;
      xs0    <= '0;
      xs1    <= '0;
      ys0    <= '0;
      ys1    <= '0;
      zw0    <= '0;
      zw1    <= '0;
      zh0    <= '0;
      zh1    <= '0;
      ci0    <= 1'b0;
      ci1    <= 1'b0;
      first  <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            xs0    <= x0_i;
            xs1    <= x1_i;
            ys0    <= y0_i ^ {K{sub_i}};
            ys1    <= y1_i;
            ci0    <= sub_i;
            ci1    <= 1'b0;
            first  <= 1'b1;
            r_cnt  <= '0;
            mask   <= {{(K-1){1'b0}}, 1'b1};
            zw0    <= '0;
            zw1    <= '0;
            busy_o <= 1'b1;
            state  <= ST_PHASE1;
          end
        end
        ST_PHASE1: begin
          state <= ST_PHASE2;
        end
        ST_PHASE2: begin
          first <= 1'b0;
          zw0   <= zw0 | (mask[K-2:0] & {(K-1){zb0}});
          zw1   <= zw1 | (mask[K-2:0] & {(K-1){zb1}});
          if (r_cnt == R_LAST) begin
            done_o <= 1'b1;
            state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + RW'(1);
            mask  <= mask << 1;
            state <= ST_PHASE1;
          end
        end
        ST_DONE: begin
          zh0    <= {msb0, zw0};
          zh1    <= {msb1, zw1};
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The working shares are only shown once complete, in the DONE cycle.
  assign z0_o = (state == ST_DONE) ? {msb0, zw0} : zh0;
  assign z1_o = (state == ST_DONE) ? {msb1, zw1} : zh1;

endmodule

// File: tb/tb_sec_add_seq.sv
// Scoreboard bench for sec_add_seq at K=16, K=5 and K=2 against an arithmetic model.
module tb_sec_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic       rst;
  logic [2:0] start, sub;
  logic [2:0] rnd16, rnd5, rnd2;
  logic [15:0] x0_16, x1_16, y0_16, y1_16;
  logic [4:0]  x0_5, x1_5, y0_5, y1_5;
  logic [1:0]  x0_2, x1_2, y0_2, y1_2;
  logic [15:0] z0_16, z1_16;
  logic [4:0]  z0_5, z1_5;
  logic [1:0]  z0_2, z1_2;
  logic        busy16, busy5, busy2, done16, done5, done2;
  logic [2:0]  busy, done;
  logic [15:0] z0a [3];
  logic [15:0] z1a [3];

  assign busy = {busy2, busy5, busy16};
  assign done = {done2, done5, done16};
  assign z0a[0] = z0_16;
  assign z1a[0] = z1_16;
  assign z0a[1] = {11'b0, z0_5};
  assign z1a[1] = {11'b0, z1_5};
  assign z0a[2] = {14'b0, z0_2};
  assign z1a[2] = {14'b0, z1_2};

  sec_add_seq #(.K(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .sub_i(sub[0]),
    .x0_i(x0_16), .x1_i(x1_16), .y0_i(y0_16), .y1_i(y1_16), .rnd_i(rnd16),
    .busy_o(busy16), .done_o(done16), .z0_o(z0_16), .z1_o(z1_16));

  sec_add_seq #(.K(5)) dut5 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .sub_i(sub[1]),
    .x0_i(x0_5), .x1_i(x1_5), .y0_i(y0_5), .y1_i(y1_5), .rnd_i(rnd5),
    .busy_o(busy5), .done_o(done5), .z0_o(z0_5), .z1_o(z1_5));

  sec_add_seq #(.K(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .sub_i(sub[2]),
    .x0_i(x0_2), .x1_i(x1_2), .y0_i(y0_2), .y1_i(y1_2), .rnd_i(rnd2),
    .busy_o(busy2), .done_o(done2), .z0_o(z0_2), .z1_o(z1_2));

  logic [15:0] exp_z [3][$];
  int          exp_t [3][$];
  logic [15:0] last_z  [3];
  logic [15:0] last_z0 [3];
  int          t_start;

  function automatic int kof(input int d);
    return (d == 0) ? 16 : ((d == 1) ? 5 : 2);
  endfunction

  function automatic logic [15:0] mk(input int d);
    return 16'((32'd1 << kof(d)) - 32'd1);
  endfunction

  // Reference: plain modular add/subtract of the recombined operands.
  function automatic logic [15:0] ref_z(input int d, input bit s, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    r = s ? (x - y) : (x + y);
    return r & mk(d);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
    end
  endtask

  task automatic issue(input int d, input bit s, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] b0, input logic [15:0] b1, input bit expect_it);
    @(negedge clk);
    t_start  = cyc;
    sub[d]   = s;
    start[d] = 1'b1;
    case (d)
      0: begin x0_16 = a0; x1_16 = a1; y0_16 = b0; y1_16 = b1; end
      1: begin x0_5 = a0[4:0]; x1_5 = a1[4:0]; y0_5 = b0[4:0]; y1_5 = b1[4:0]; end
      default: begin x0_2 = a0[1:0]; x1_2 = a1[1:0]; y0_2 = b0[1:0]; y1_2 = b1[1:0]; end
    endcase
    if (expect_it) begin
      exp_z[d].push_back(ref_z(d, s, a0 ^ a1, b0 ^ b1));
      exp_t[d].push_back(cyc + 2 * kof(d) - 1);
    end
    @(negedge clk);
    start[d] = 1'b0;
    x0_16 = 16'($urandom);
    y0_16 = 16'($urandom);
  endtask

  task automatic issue_m(input int d, input bit s, input logic [15:0] x, input logic [15:0] y, input bit expect_it);
    logic [15:0] a0, b0;
    a0 = 16'($urandom) & mk(d);
    b0 = 16'($urandom) & mk(d);
    issue(d, s, a0, a0 ^ x, b0, b0 ^ y, expect_it);
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < 100; i++) begin
      if (exp_z[d].size() == 0) break;
      @(negedge clk);
    end
    if (exp_z[d].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d: %0d results still pending at cycle %0d", d, exp_z[d].size(), cyc);
      exp_z[d].delete();
      exp_t[d].delete();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      rnd16 = 3'($urandom);
      rnd5  = 3'($urandom);
      rnd2  = 3'($urandom);
    end
  end

  // Monitor: every done_o pops one expectation and checks value, latency, busy.
  initial begin
    logic [15:0] ez;
    int          et;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (done[d] === 1'b1) begin
          last_z0[d] = z0a[d];
          last_z[d]  = z0a[d] ^ z1a[d];
          if (exp_z[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut%0d at cycle %0d: z=%h", d, cyc, last_z[d]);
          end else begin
            ez = exp_z[d].pop_front();
            et = exp_t[d].pop_front();
            checks++;
            if (last_z[d] !== ez) begin
              errors++;
              $display("FAIL result dut%0d at cycle %0d: got %h, expected %h", d, cyc, last_z[d], ez);
            end
            checks++;
            if (cyc != et) begin
              errors++;
              $display("FAIL latency dut%0d: done at cycle %0d, expected cycle %0d", d, cyc, et);
            end
            checks++;
            if (busy[d] !== 1'b1) begin
              errors++;
              $display("FAIL busy_at_done dut%0d at cycle %0d: got %b, expected 1", d, cyc, busy[d]);
            end
          end
        end
      end
    end
  end

  initial begin
    int          t0;
    int          nvar;
    logic [15:0] z0_first;
    logic [15:0] xr, yr;
    logic        seen;
    rst = 1'b1;
    start = '0;
    sub = '0;
    x0_16 = '0; x1_16 = '0; y0_16 = '0; y1_16 = '0;
    x0_5 = '0; x1_5 = '0; y0_5 = '0; y1_5 = '0;
    x0_2 = '0; x1_2 = '0; y0_2 = '0; y1_2 = '0;
    for (int d = 0; d < 3; d++) begin
      last_z[d] = '0;
      last_z0[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_busy", {15'b0, busy[d]}, 16'h0);
      check("reset_done", {15'b0, done[d]}, 16'h0);
      check("reset_z0", z0a[d], 16'h0);
      check("reset_z1", z1a[d], 16'h0);
    end
    rst = 1'b0;

    issue(0, 1'b0, 16'hA5A5, 16'hB791, 16'h0F0F, 16'h00F0, 1'b1);
    wait_done(0);
    check("add_directed", last_z[0], 16'h2233);

    issue_m(0, 1'b1, 16'h0000, 16'h0001, 1'b1);
    wait_done(0);
    check("sub_wrap", last_z[0], 16'hFFFF);
    issue_m(0, 1'b0, 16'hFFFF, 16'h0001, 1'b1);
    wait_done(0);
    check("add_wrap", last_z[0], 16'h0000);

    nvar = 0;
    z0_first = '0;
    for (int i = 0; i < 50; i++) begin
      issue_m(0, 1'b0, 16'h1234, 16'h0FFF, 1'b1);
      wait_done(0);
      check("mask_indep", last_z[0], 16'h2233);
      if (i == 0) z0_first = last_z0[0];
      else if (last_z0[0] !== z0_first) nvar++;
    end
    checks++;
    if (nvar == 0) begin
      errors++;
      $display("FAIL z0_varies: got %0d differing z0 values, expected at least 1", nvar);
    end

    for (int i = 0; i < 20; i++) begin
      xr = 16'($urandom);
      yr = 16'($urandom);
      issue_m(0, 1'($urandom_range(0, 1)), xr, yr, 1'b1);
      wait_done(0);
    end

    issue_m(0, 1'b0, 16'h1111, 16'h2222, 1'b1);
    t0 = t_start;
    check("busy_after_start", {15'b0, busy[0]}, 16'h1);
    repeat (3) @(negedge clk);
    issue_m(0, 1'b1, 16'h7777, 16'h0123, 1'b0);
    while (cyc < t0 + 31) @(negedge clk);
    check("done_at_t31", {15'b0, done[0]}, 16'h1);
    issue_m(0, 1'b0, 16'h4000, 16'h0321, 1'b1);
    check("restart_after_done", {15'b0, busy[0]}, 16'h1);
    wait_done(0);

    issue_m(0, 1'b0, 16'hBEEF, 16'h1111, 1'b1);
    t0 = t_start;
    while (cyc < t0 + 10) @(negedge clk);
    rst = 1'b1;
    exp_z[0].delete();
    exp_t[0].delete();
    @(negedge clk);
    rst = 1'b0;
    check("midop_rst_busy", {15'b0, busy[0]}, 16'h0);
    check("midop_rst_done", {15'b0, done[0]}, 16'h0);
    check("midop_rst_z0", z0a[0], 16'h0);
    check("midop_rst_z1", z1a[0], 16'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done[0] === 1'b1) seen = 1'b1;
    end
    check("no_done_after_rst", {15'b0, seen}, 16'h0);

    @(negedge clk);
    rst = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start[0] = 1'b0;
    check("rst_beats_start", {15'b0, busy[0]}, 16'h0);
    repeat (35) @(negedge clk);

    for (int d = 1; d < 3; d++) begin
      for (int s = 0; s < 2; s++) begin
        for (int x = 0; x < (1 << kof(d)); x++) begin
          for (int y = 0; y < (1 << kof(d)); y++) begin
            issue_m(d, 1'(s), 16'(x), 16'(y), 1'b1);
            wait_done(d);
          end
        end
      end
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
